// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the RV32M divide sequencer
//
// Purpose: op encodings, FSM state encoding, numeric constants and small
// helpers shared by div32_ctrl, div_sign_fix and the future pipelined divider.
// Ports: none (package).

package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [31:0] INT_MIN      = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES     = 32'hFFFF_FFFF;
  localparam int          ITER_DEFAULT = 32;

  // Bit 0 of the op selects unsigned, bit 1 selects remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

  // Two's complement magnitude; INT_MIN maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - sign correction and result select for an unsigned divider core
//
// Purpose: turns the unsigned quotient/remainder of magnitudes into the RV32M
// result for the requested op. Purely combinational.
// Ports:
//   quoti  in  32  raw quotient of the magnitudes
//   remai  in  32  raw remainder of the magnitudes
//   op     in  2   request op (DIV/DIVU/REM/REMU)
//   sa     in  1   sign of the original dividend
//   sb     in  1   sign of the original divisor
//   result out 32  corrected, selected result

module div_sign_fix
  import div_pkg::*;
(
  input  logic [31:0] quoti,
  input  logic [31:0] remai,
  input  logic [1:0]  op,
  input  logic        sa,
  input  logic        sb,
  output logic [31:0] result
);

  logic neg_q;
  logic neg_r;

  // Quotient takes the xor of the operand signs; remainder follows the dividend.
  assign neg_q = op_is_signed(op) & (sa ^ sb);
  assign neg_r = op_is_signed(op) & sa;

  always_comb begin
    result = quoti;
    if (op_is_rem(op)) begin
      result = neg_r ? (~remai + 32'd1) : remai;
    end else begin
      result = neg_q ? (~quoti + 32'd1) : quoti;
    end
  end

endmodule

// File: rtl/div32_ctrl.sv
// rtl/div32_ctrl.sv - issue/writeback sequencer in front of the 32-bit sequential divider core
//
// Purpose: accepts one RV32M DIV/DIVU/REM/REMU request at a time, feeds operand
// magnitudes to the external divider core, waits ITER core iterations, applies
// sign correction and returns the result with its tag. Divide-by-zero and
// signed overflow are answered directly without running the core.
// Ports:
//   clk, rst                     clock, async active-low reset
//   req_valid/req_ready          request handshake
//   req_op, req_a, req_b, req_tag request payload
//   resp_valid/resp_ready        response handshake
//   resp_data, resp_tag          response payload
//   busy                         high whenever an operation is in flight
//   core_load                    load strobe to the core (held high in reset)
//   core_dived, core_divor       operand magnitudes to the core
//   core_quoti, core_remai       core results

module div32_ctrl
  import div_pkg::*;
#(
  parameter int ITER  = ITER_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic             core_load,
  output logic [31:0]      core_dived,
  output logic [31:0]      core_divor,
  input  logic [31:0]      core_quoti,
  input  logic [31:0]      core_remai
);

  localparam int              CNT_W    = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             sa_q;
  logic             sb_q;
  logic [31:0]      fix_result;

  logic             req_signed;
  logic             req_div_zero;
  logic             req_overflow;

  assign req_signed   = op_is_signed(req_op);
  assign req_div_zero = (req_b == 32'd0);
  assign req_overflow = req_signed && (req_a == INT_MIN) && (req_b == ALL_ONES);

  // Decoded from the state register; reset forces the core into load so it
  // stays parked while this block is held in reset.
  assign req_ready  = (state == S_IDLE) & rst;
  assign resp_valid = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign core_load  = ~rst | (state == S_LOAD);

  div_sign_fix u_sign_fix (
    .quoti  (core_quoti),
    .remai  (core_remai),
    .op     (op_q),
    .sa     (sa_q),
    .sb     (sb_q),
    .result (fix_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      op_q       <= 2'b00;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      resp_data  <= 32'd0;
      resp_tag   <= '0;
      core_dived <= 32'd0;
      core_divor <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            resp_tag   <= req_tag;
            sa_q       <= req_a[31];
            sb_q       <= req_b[31];
            core_dived <= req_signed ? abs32(req_a) : req_a;
            core_divor <= req_signed ? abs32(req_b) : req_b;
            if (req_div_zero) begin
              resp_data <= op_is_rem(req_op) ? req_a : ALL_ONES;
              state     <= S_DONE;
            end else if (req_overflow) begin
              resp_data <= op_is_rem(req_op) ? 32'd0 : INT_MIN;
              state     <= S_DONE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          resp_data <= fix_result;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div32_ctrl.sv
// tb/tb_div32_ctrl.sv - self-checking bench for div32_ctrl with a behavioural divider core

module tb_div32_ctrl;

  localparam int ITER  = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic             core_load;
  logic [31:0]      core_dived;
  logic [31:0]      core_divor;
  logic [31:0]      core_quoti;
  logic [31:0]      core_remai;

  int checks   = 0;
  int failures = 0;

  div32_ctrl #(.ITER(ITER), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_tag    (req_tag),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .busy       (busy),
    .core_load  (core_load),
    .core_dived (core_dived),
    .core_divor (core_divor),
    .core_quoti (core_quoti),
    .core_remai (core_remai)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core: results only become visible ITER edges after the load
  // strobe is released; before that the outputs carry recognisable garbage.
  logic [31:0] m_d;
  logic [31:0] m_v;
  int          m_cnt = 0;
  int          load_pulses = 0;

  always @(posedge clk) begin
    if (core_load) begin
      m_d   <= core_dived;
      m_v   <= core_divor;
      m_cnt <= 0;
    end else if (m_cnt < ITER) begin
      m_cnt <= m_cnt + 1;
    end
    if (rst && core_load) load_pulses <= load_pulses + 1;
  end

  assign core_quoti = (m_cnt == ITER && m_v != 0) ? m_d / m_v : 32'hDEAD_BEEF;
  assign core_remai = (m_cnt == ITER && m_v != 0) ? m_d % m_v : 32'hBAAD_F00D;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == 2'd0) || (op == 2'd2);
    return (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // RV32M results from the ISA rules, using signed/unsigned integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      2'd1: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input int hold, input string name);
    int          waitc;
    int          edges;
    int          p0;
    logic [31:0] exp;
    exp   = ref_result(op, a, b);
    waitc = 0;
    while (!req_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk({name, "_req_ready"}, 32'(req_ready), 32'd1);
    p0        = load_pulses;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(posedge clk); #1;
    // Keep junk on the request bus while busy; it must be ignored.
    req_op  = 2'($urandom);
    req_a   = $urandom;
    req_b   = $urandom;
    req_tag = TAG_W'($urandom);
    edges   = 1;
    while (!resp_valid && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
    req_valid = 1'b0;
    chk({name, "_latency"}, 32'(edges), is_special(op, a, b) ? 32'd1 : 32'(ITER + 3));
    chk({name, "_data"}, resp_data, exp);
    chk({name, "_tag"}, 32'(resp_tag), 32'(tag));
    chk({name, "_loads"}, 32'(load_pulses - p0), is_special(op, a, b) ? 32'd0 : 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({name, "_hold_data"}, resp_data, exp);
      chk({name, "_hold_tag"}, 32'(resp_tag), 32'(tag));
      chk({name, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      chk({name, "_hold_busy"}, 32'(busy), 32'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({name, "_valid_drop"}, 32'(resp_valid), 32'd0);
    chk({name, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int          seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          mode;

    rst        = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    req_a      = 32'd0;
    req_b      = 32'd0;
    req_tag    = '0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_load", 32'(core_load), 32'd1);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk("rst_dived", core_dived, 32'd0);
    chk("rst_divor", core_divor, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_core_load", 32'(core_load), 32'd0);

    do_op(2'd1, 32'd100, 32'd7, 5'd3, 0, "divu_100_7");
    do_op(2'd3, 32'd100, 32'd7, 5'd4, 0, "remu_100_7");
    do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, "div_m7_2");
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, "rem_m7_2");
    do_op(2'd0, 32'd7, 32'hFFFF_FFFE, 5'd7, 0, "div_7_m2");
    do_op(2'd2, 32'd7, 32'hFFFF_FFFE, 5'd8, 0, "rem_7_m2");
    do_op(2'd1, 32'd5, 32'd0, 5'd9, 0, "divu_by0");
    do_op(2'd2, 32'hFFFF_FFFB, 32'd0, 5'd10, 0, "rem_by0");
    do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, "div_ovf");
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, "rem_ovf");
    do_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, "divu_big");

    do_op(2'd1, 32'd100, 32'd7, 5'd14, 10, "backpressure");
    do_op(2'd1, 32'd9, 32'd3, 5'd15, 0, "back_to_back");

    // Abort in RUN with the iteration counter at 10.
    req_valid = 1'b1;
    req_op    = 2'd0;
    req_a     = 32'd12345;
    req_b     = 32'd17;
    req_tag   = 5'd20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_core_load", 32'(core_load), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b1;
    seen = 0;
    for (int i = 0; i < ITER + 8; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen++;
    end
    chk("abort_no_stale_resp", 32'(seen), 32'd0);
    do_op(2'd1, 32'd1000, 32'd10, 5'd21, 0, "after_abort");

    for (int n = 0; n < 24; n++) begin
      rop  = 2'($urandom_range(0, 3));
      ra   = $urandom;
      rb   = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) rb = 32'd0;
      else if (mode == 1) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end else if (mode == 2) rb = $urandom_range(1, 15);
      else if (mode == 3) rb = -32'($urandom_range(1, 15));
      do_op(rop, ra, rb, TAG_W'($urandom), $urandom_range(0, 2), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
